// File: rtl/dma_desc_fetch.sv
// Descriptor ring fetcher: bursts each descriptor from host memory over Avalon-MM,
// checks its OWN bit and pushes it as one word into the dma_desc_proc FIFO.
module dma_desc_fetch #(
  parameter int DESC_WORDS = 8,
  parameter int IDX_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [31:0]               ring_base_i,
  input  logic [IDX_W-1:0]          ring_size_i,
  input  logic                      doorbell_i,
  input  logic [IDX_W-1:0]          doorbell_cnt_i,
  output logic [31:0]               avm_address_o,
  output logic                      avm_read_o,
  output logic [3:0]                avm_burstcount_o,
  input  logic                      avm_waitrequest_i,
  input  logic [31:0]               avm_readdata_i,
  input  logic                      avm_readdatavalid_i,
  output logic                      dma_desc_fifo_wr_o,
  output logic [32*DESC_WORDS+8:0]  dma_desc_fifo_wrdata_o,
  input  logic                      dma_desc_fifo_almost_full_i,
  output logic                      busy_o,
  output logic [IDX_W-1:0]          head_idx_o,
  output logic                      own_err_o
);

  localparam int ASM_W  = 32 * DESC_WORDS;
  localparam int BEAT_W = $clog2(DESC_WORDS);
  localparam int OFS_W  = $clog2(DESC_WORDS * 4);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic [2:0]              state;
  logic                    enable;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        pending;
  logic [IDX_W-1:0]        pending_nxt;
  logic [IDX_W:0]          pending_sum;
  logic [31:0]             base;
  logic [IDX_W-1:0]        size;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [ASM_W-1:0]        asm_q;
  logic [32*DESC_WORDS+8:0] wrdata_q;

  // Doorbell add and push decrement share one saturating adder.
  always_comb begin
    pending_sum = {1'b0, pending} + {1'b0, (doorbell_i ? doorbell_cnt_i : {IDX_W{1'b0}})};
    if (state == S_PUSH)
      pending_sum = pending_sum - (IDX_W+1)'(1);
    pending_nxt = pending_sum[IDX_W] ? '1 : pending_sum[IDX_W-1:0];
  end

  always_comb begin
    avm_read_o             = (state == S_REQ);
    avm_address_o          = base + 32'({idx, {OFS_W{1'b0}}});
    avm_burstcount_o       = (state == S_REQ) ? 4'(DESC_WORDS) : '0;
    dma_desc_fifo_wr_o     = (state == S_PUSH);
    dma_desc_fifo_wrdata_o = wrdata_q;
    busy_o                 = (state != S_IDLE) && (state != S_HALT);
    head_idx_o             = idx;
    own_err_o              = (state == S_CHECK) && !asm_q[ASM_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      enable   <= 1'b0;
      idx      <= '0;
      pending  <= '0;
      base     <= '0;
      size     <= '0;
      beat_cnt <= '0;
      asm_q    <= '0;
      wrdata_q <= '0;
    end else begin
      pending <= pending_nxt;
      case (state)
        S_IDLE: begin
          if (enable && (pending != '0) && !dma_desc_fifo_almost_full_i)
            state <= S_REQ;
        end
        S_REQ: begin
          if (!avm_waitrequest_i) begin
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (avm_readdatavalid_i) begin
            for (int unsigned k = 0; k < DESC_WORDS; k++)
              if (beat_cnt == BEAT_W'(k))
                asm_q[32*k +: 32] <= avm_readdata_i;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_W'(DESC_WORDS - 1))
              state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (asm_q[ASM_W-1]) begin
            wrdata_q <= {asm_q[ASM_W-1 -: 8], 1'b1, asm_q};
            state    <= S_PUSH;
          end else begin
            enable <= 1'b0;
            state  <= S_HALT;
          end
        end
        S_PUSH: begin
          idx   <= (idx == size - 1'b1) ? '0 : idx + 1'b1;
          state <= S_IDLE;
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase

      // Start overrides everything else, but only while no burst is in flight.
      if (start_i && (ring_size_i != '0) && ((state == S_IDLE) || (state == S_HALT))) begin
        base    <= ring_base_i;
        size    <= ring_size_i;
        idx     <= '0;
        pending <= '0;
        enable  <= 1'b1;
        state   <= S_IDLE;
      end
    end
  end

endmodule
